// File: rtl/mem_ctrl.sv
// mem_ctrl: rv32i load/store access decoder.
// Turns opcode/funct3/addr_lsb into access size, direction, byte lane
// enables and misaligned/illegal flags, all combinationally. A registered
// sticky flag remembers any faulting access until cleared.
// Optional build macro: MEM_CTRL_STATS_EN adds 32-bit load/store counters.
module mem_ctrl #(
    parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
    parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lsb,
    input  logic        fault_clr,
    output logic [1:0]  access_size,
    output logic        write_to_data_mem,
    output logic        require_mem_access,
    output logic        load_unsigned,
    output logic [3:0]  byte_en,
    output logic        misaligned,
    output logic        illegal_op,
    output logic        fault_sticky
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count
`endif
);

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_NONE = 2'b11;

    logic [1:0] size_dec;
    logic       wr_dec;
    logic       req_dec;
    logic       lu_dec;
    logic       ill_dec;
    logic [3:0] lane_en;
    logic       mis_dec;

    // Opcode/funct3 decode. case matching is exact, so X/Z opcodes fall to
    // the default arm and every output stays at its safe "no access" value.
    always_comb begin
        size_dec = SIZE_NONE;
        wr_dec   = 1'b0;
        req_dec  = 1'b0;
        lu_dec   = 1'b0;
        ill_dec  = 1'b0;
        case (opcode)
            LOAD_OPCODE: begin
                case (funct3)
                    3'b000: begin size_dec = SIZE_BYTE; req_dec = 1'b1; end
                    3'b001: begin size_dec = SIZE_HALF; req_dec = 1'b1; end
                    3'b010: begin size_dec = SIZE_WORD; req_dec = 1'b1; end
                    3'b100: begin size_dec = SIZE_BYTE; req_dec = 1'b1; lu_dec = 1'b1; end
                    3'b101: begin size_dec = SIZE_HALF; req_dec = 1'b1; lu_dec = 1'b1; end
                    default: ill_dec = 1'b1;
                endcase
            end
            STORE_OPCODE: begin
                case (funct3)
                    3'b000: begin size_dec = SIZE_BYTE; req_dec = 1'b1; wr_dec = 1'b1; end
                    3'b001: begin size_dec = SIZE_HALF; req_dec = 1'b1; wr_dec = 1'b1; end
                    3'b010: begin size_dec = SIZE_WORD; req_dec = 1'b1; wr_dec = 1'b1; end
                    default: ill_dec = 1'b1;
                endcase
            end
            default: begin
                size_dec = SIZE_NONE;
            end
        endcase
    end

    // Byte-lane enables and alignment check. A misaligned access keeps its
    // decoded size/direction but gets no lanes, which is what stops memory.
    always_comb begin
        lane_en = 4'b0000;
        mis_dec = 1'b0;
        if (req_dec) begin
            case (size_dec)
                SIZE_WORD: begin
                    if (addr_lsb == 2'b00) lane_en = 4'b1111;
                    else                   mis_dec = 1'b1;
                end
                SIZE_HALF: begin
                    if (addr_lsb[0] == 1'b0) lane_en = addr_lsb[1] ? 4'b1100 : 4'b0011;
                    else                     mis_dec = 1'b1;
                end
                SIZE_BYTE: begin
                    lane_en = 4'b0001 << addr_lsb;
                end
                default: begin
                    lane_en = 4'b0000;
                end
            endcase
        end
    end

    assign access_size        = size_dec;
    assign write_to_data_mem  = wr_dec;
    assign require_mem_access = req_dec;
    assign load_unsigned      = lu_dec;
    assign byte_en            = lane_en;
    assign misaligned         = mis_dec;
    assign illegal_op         = ill_dec;

    // Sticky fault flag: reset, then clear (wins over a new fault), then set.
    always_ff @(posedge clk) begin
        if (rst)
            fault_sticky <= 1'b0;
        else if (fault_clr)
            fault_sticky <= 1'b0;
        else if (mis_dec || ill_dec)
            fault_sticky <= 1'b1;
    end

`ifdef MEM_CTRL_STATS_EN
    logic counted;
    assign counted = req_dec && !mis_dec;

    // Completed-access counters; they wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
        end else if (counted) begin
            if (wr_dec) store_count <= store_count + 32'd1;
            else        load_count  <= load_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with an expected-value queue.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  addr_lsb;
    logic        fault_clr;
    logic [1:0]  access_size;
    logic        write_to_data_mem;
    logic        require_mem_access;
    logic        load_unsigned;
    logic [3:0]  byte_en;
    logic        misaligned;
    logic        illegal_op;
    logic        fault_sticky;
`ifdef MEM_CTRL_STATS_EN
    logic [31:0] load_count;
    logic [31:0] store_count;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] size;
        logic       wr;
        logic       req;
        logic       lu;
        logic [3:0] be;
        logic       mis;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];

    mem_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .funct3             (funct3),
        .addr_lsb           (addr_lsb),
        .fault_clr          (fault_clr),
        .access_size        (access_size),
        .write_to_data_mem  (write_to_data_mem),
        .require_mem_access (require_mem_access),
        .load_unsigned      (load_unsigned),
        .byte_en            (byte_en),
        .misaligned         (misaligned),
        .illegal_op         (illegal_op),
        .fault_sticky       (fault_sticky)
`ifdef MEM_CTRL_STATS_EN
        ,
        .load_count         (load_count),
        .store_count        (store_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] size, input logic wr, input logic req,
                                input logic lu, input logic [3:0] be, input logic mis,
                                input logic ill);
        exp_t e;
        e.size = size; e.wr = wr; e.req = req; e.lu = lu;
        e.be = be; e.mis = mis; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".size"}, {30'd0, access_size},        {30'd0, e.size});
        chk({tag, ".wr"},   {31'd0, write_to_data_mem},  {31'd0, e.wr});
        chk({tag, ".req"},  {31'd0, require_mem_access}, {31'd0, e.req});
        chk({tag, ".lu"},   {31'd0, load_unsigned},      {31'd0, e.lu});
        chk({tag, ".be"},   {28'd0, byte_en},            {28'd0, e.be});
        chk({tag, ".mis"},  {31'd0, misaligned},         {31'd0, e.mis});
        chk({tag, ".ill"},  {31'd0, illegal_op},         {31'd0, e.ill});
    endtask

    // Drive one access at the current (negedge) time, queue its expectation,
    // then sample the combinational outputs 1 ns later.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [1:0] lsb, input logic clr, input exp_t e);
        opcode    = op;
        funct3    = f3;
        addr_lsb  = lsb;
        fault_clr = clr;
        sb_q.push_back(e);
        #1;
        check_out(tag);
    endtask

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;

    initial begin
        rst = 1'b1; opcode = RT; funct3 = 3'b000; addr_lsb = 2'b00; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.sticky", {31'd0, fault_sticky}, 32'd0);
        rst = 1'b0;

        // loads, aligned
        step("lb",  LD, 3'b000, 2'b00, 1'b0, mk(2'b10, 0, 1, 0, 4'b0001, 0, 0)); @(negedge clk);
        step("lh",  LD, 3'b001, 2'b00, 1'b0, mk(2'b01, 0, 1, 0, 4'b0011, 0, 0)); @(negedge clk);
        step("lw",  LD, 3'b010, 2'b00, 1'b0, mk(2'b00, 0, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("lbu", LD, 3'b100, 2'b00, 1'b0, mk(2'b10, 0, 1, 1, 4'b0001, 0, 0)); @(negedge clk);
        step("lhu", LD, 3'b101, 2'b00, 1'b0, mk(2'b01, 0, 1, 1, 4'b0011, 0, 0)); @(negedge clk);
        // stores, aligned
        step("sb",  ST, 3'b000, 2'b00, 1'b0, mk(2'b10, 1, 1, 0, 4'b0001, 0, 0)); @(negedge clk);
        step("sh",  ST, 3'b001, 2'b00, 1'b0, mk(2'b01, 1, 1, 0, 4'b0011, 0, 0)); @(negedge clk);
        step("sw",  ST, 3'b010, 2'b00, 1'b0, mk(2'b00, 1, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        // non-memory opcodes
        step("opx", 7'bxxxxxxx, 3'b010, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 0)); @(negedge clk);
        step("rtype", RT, 3'b010, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 0)); @(negedge clk);
        // lane placement and misalignment
        step("sb11", ST, 3'b000, 2'b11, 1'b0, mk(2'b10, 1, 1, 0, 4'b1000, 0, 0)); @(negedge clk);
        step("sh10", ST, 3'b001, 2'b10, 1'b0, mk(2'b01, 1, 1, 0, 4'b1100, 0, 0)); @(negedge clk);
        chk("sticky.clean", {31'd0, fault_sticky}, 32'd0);
        step("sw01", ST, 3'b010, 2'b01, 1'b0, mk(2'b00, 1, 1, 0, 4'b0000, 1, 0)); @(negedge clk);
        chk("sticky.mis", {31'd0, fault_sticky}, 32'd1);
        step("lh11", LD, 3'b001, 2'b11, 1'b1, mk(2'b01, 0, 1, 0, 4'b0000, 1, 0)); @(negedge clk);
        chk("sticky.clr", {31'd0, fault_sticky}, 32'd0);
        // illegal store funct3
        step("st101", ST, 3'b101, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 1)); @(negedge clk);
        chk("sticky.ill", {31'd0, fault_sticky}, 32'd1);
        step("lw.hold", LD, 3'b010, 2'b00, 1'b0, mk(2'b00, 0, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        chk("sticky.hold", {31'd0, fault_sticky}, 32'd1);
        step("ld011", LD, 3'b011, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 1)); @(negedge clk);
        chk("sticky.hold2", {31'd0, fault_sticky}, 32'd1);
        step("ld110.clr", LD, 3'b110, 2'b00, 1'b1, mk(2'b11, 0, 0, 0, 4'b0000, 0, 1)); @(negedge clk);
        chk("sticky.clrwins", {31'd0, fault_sticky}, 32'd0);

        // set the flag once more, then show reset clears it
        step("st111", ST, 3'b111, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 1));
        @(negedge clk);
        chk("sticky.set2", {31'd0, fault_sticky}, 32'd1);
        rst = 1'b1;
        step("rst.comb", ST, 3'b000, 2'b01, 1'b0, mk(2'b10, 1, 1, 0, 4'b0010, 0, 0));
        @(negedge clk);
        chk("sticky.rst", {31'd0, fault_sticky}, 32'd0);
`ifdef MEM_CTRL_STATS_EN
        chk("ld_cnt.rst", load_count, 32'd0);
        chk("st_cnt.rst", store_count, 32'd0);
`endif
        rst = 1'b0;

        // 3 LW + 2 SW + 1 misaligned LW
        step("c.lw0", LD, 3'b010, 2'b00, 1'b0, mk(2'b00, 0, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("c.sw0", ST, 3'b010, 2'b00, 1'b0, mk(2'b00, 1, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("c.lw1", LD, 3'b010, 2'b00, 1'b0, mk(2'b00, 0, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("c.lwm", LD, 3'b010, 2'b10, 1'b0, mk(2'b00, 0, 1, 0, 4'b0000, 1, 0)); @(negedge clk);
        step("c.sw1", ST, 3'b010, 2'b00, 1'b0, mk(2'b00, 1, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("c.lw2", LD, 3'b010, 2'b00, 1'b0, mk(2'b00, 0, 1, 0, 4'b1111, 0, 0)); @(negedge clk);
        step("c.idle", RT, 3'b000, 2'b00, 1'b0, mk(2'b11, 0, 0, 0, 4'b0000, 0, 0)); @(negedge clk);
        chk("sticky.cnt", {31'd0, fault_sticky}, 32'd1);
`ifdef MEM_CTRL_STATS_EN
        chk("ld_cnt", load_count, 32'd3);
        chk("st_cnt", store_count, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("ld_cnt.rst2", load_count, 32'd0);
        chk("st_cnt.rst2", store_count, 32'd0);
        rst = 1'b0;
`endif
        chk("queue.empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
